// File: rtl/water_pkg.sv
// rtl/water_pkg.sv - shared FSM state type and default level constants for the water level controller
package water_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUMP = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_LEVEL_W     = 4;
  localparam int DEF_SAFE_LEVEL  = 6;
  localparam int DEF_ALARM_LEVEL = 9;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running divider producing a one-cycle tick every DIV clocks
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/water_level_matrix_ctrl.sv
// rtl/water_level_matrix_ctrl.sv - pump-down level tracker with a scanned red/green LED bar-graph matrix
module water_level_matrix_ctrl
  import water_pkg::*;
#(
  parameter int N_ROWS      = 8,
  parameter int N_COLS      = 8,
  parameter int LEVEL_W     = DEF_LEVEL_W,
  parameter int SAFE_LEVEL  = DEF_SAFE_LEVEL,
  parameter int ALARM_LEVEL = DEF_ALARM_LEVEL,
  parameter int TICK_DIV    = 50_000_000,
  parameter int SCAN_DIV    = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LEVEL_W-1:0] level_in,
  input  logic               load,
  input  logic [1:0]         speed,
  output logic [N_ROWS-1:0]  row_data,
  output logic [N_COLS-1:0]  red_column_data,
  output logic [N_COLS-1:0]  green_column_data,
  output logic [LEVEL_W-1:0] water_level,
  output logic               pumping,
  output logic               alarm
);

  localparam int RW  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int LW1 = LEVEL_W + 1;
  localparam int PW  = LEVEL_W + RW + 1;

  logic tick, scan_tick;

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               blink_q, blink_d;
  logic [RW-1:0]      row_idx_q, row_idx_d;
  logic [N_ROWS-1:0]  row_data_q, row_data_d;
  logic [N_COLS-1:0]  red_q, red_d, green_q, green_d;

  logic [LW1-1:0] over_safe, level_sub;
  logic [PW-1:0]  lit_rows;
  logic           lit;

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  tick_gen #(.DIV(SCAN_DIV)) u_scan_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (scan_tick)
  );

  assign alarm   = ({1'b0, level_q} >= LW1'(ALARM_LEVEL));
  assign pumping = (state_q == PUMP);

  // Margin above the safe level, one bit wider so the compare never wraps.
  assign over_safe = {1'b0, level_q} - LW1'(SAFE_LEVEL);
  assign level_sub = {1'b0, level_q} - LW1'(speed);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (load) begin
      level_d = level_in;
      state_d = ({1'b0, level_in} > LW1'(SAFE_LEVEL)) ? PUMP : IDLE;
    end else if (state_q == PUMP && tick && speed != 2'd0) begin
      if ({1'b0, level_q} > LW1'(SAFE_LEVEL) && over_safe > LW1'(speed)) begin
        level_d = level_sub[LEVEL_W-1:0];
      end else begin
        level_d = LEVEL_W'(SAFE_LEVEL);
        state_d = DONE;
      end
    end
  end

  always_comb begin
    blink_d = blink_q;
    if (!alarm)    blink_d = 1'b1;
    else if (tick) blink_d = ~blink_q;
  end

  // Bar height in rows; the product is kept full width before scaling back down.
  assign lit_rows = (PW'(level_q) * PW'(N_ROWS)) >> LEVEL_W;
  assign lit      = (PW'(row_idx_q) < lit_rows);

  always_comb begin
    row_idx_d = row_idx_q;
    if (scan_tick) row_idx_d = (row_idx_q == RW'(N_ROWS - 1)) ? '0 : row_idx_q + 1'b1;
    row_data_d = ~(N_ROWS'(1) << row_idx_q);
    red_d      = (lit && alarm && blink_q) ? '1 : '0;
    green_d    = (lit && !alarm) ? '1 : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      level_q    <= '0;
      blink_q    <= 1'b1;
      row_idx_q  <= '0;
      row_data_q <= '1;
      red_q      <= '0;
      green_q    <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      blink_q    <= blink_d;
      row_idx_q  <= row_idx_d;
      row_data_q <= row_data_d;
      red_q      <= red_d;
      green_q    <= green_d;
    end
  end

  assign row_data          = row_data_q;
  assign red_column_data   = red_q;
  assign green_column_data = green_q;
  assign water_level       = level_q;

endmodule

// File: tb/tb_water_level_matrix_ctrl.sv
// tb/tb_water_level_matrix_ctrl.sv - directed self-checking bench for water_level_matrix_ctrl
module tb_water_level_matrix_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] level_in;
  logic       load;
  logic [1:0] speed;
  logic [7:0] row_data;
  logic [7:0] red_column_data;
  logic [7:0] green_column_data;
  logic [3:0] water_level;
  logic       pumping;
  logic       alarm;

  int checks   = 0;
  int failures = 0;

  water_level_matrix_ctrl #(
    .N_ROWS(8), .N_COLS(8), .LEVEL_W(4), .SAFE_LEVEL(6), .ALARM_LEVEL(9),
    .TICK_DIV(4), .SCAN_DIV(2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .level_in          (level_in),
    .load              (load),
    .speed             (speed),
    .row_data          (row_data),
    .red_column_data   (red_column_data),
    .green_column_data (green_column_data),
    .water_level       (water_level),
    .pumping           (pumping),
    .alarm             (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [3:0] lvl);
    level_in = lvl;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  task automatic wait_level_change(input string tag, input logic [3:0] old);
    int n = 0;
    while (water_level === old && n < 16) begin
      step();
      n++;
    end
    check(tag, 32'(water_level !== old), 32'd1);
  endtask

  task automatic wait_row_change(input logic [7:0] old, output bit ok);
    int n = 0;
    while (row_data === old && n < 8) begin
      step();
      n++;
    end
    ok = (row_data !== old);
  endtask

  function automatic int row_of(input logic [7:0] rd);
    int r = -1;
    for (int i = 0; i < 8; i++) if (rd == ~(8'(1) << i)) r = i;
    return r;
  endfunction

  initial begin
    logic [7:0] prev, exp_rd, exp_g;
    bit ok;
    int n, r, on_cnt, off_cnt, bad_cnt;

    rst = 1'b0; load = 1'b0; level_in = 4'd0; speed = 2'd0;
    step();
    step();
    check("rst_row_data", 32'(row_data), 32'hFF);
    check("rst_red", 32'(red_column_data), 32'h00);
    check("rst_green", 32'(green_column_data), 32'h00);
    check("rst_level", 32'(water_level), 32'd0);
    check("rst_pumping", 32'(pumping), 32'd0);
    check("rst_alarm", 32'(alarm), 32'd0);
    rst = 1'b1;

    // Row scan order, bottom row first, wrapping back to row 0.
    n = 0;
    while (row_data !== 8'hFE && n < 20) begin
      step();
      n++;
    end
    check("scan_sync", 32'(row_data), 32'hFE);
    ok = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      prev = row_data;
      wait_row_change(prev, ok);
      exp_rd = ~(8'(1) << (k % 8));
      check($sformatf("scan_row_%0d", k), 32'(row_data), 32'(exp_rd));
    end

    // Pump 15 down to safe level at speed 3.
    speed = 2'd3;
    do_load(4'd15);
    check("p15_level", 32'(water_level), 32'd15);
    check("p15_pumping", 32'(pumping), 32'd1);
    check("p15_alarm", 32'(alarm), 32'd1);
    wait_level_change("p15_wait12", 4'd15);
    check("p15_level12", 32'(water_level), 32'd12);
    wait_level_change("p15_wait9", 4'd12);
    check("p15_level9", 32'(water_level), 32'd9);
    check("p15_alarm9", 32'(alarm), 32'd1);
    wait_level_change("p15_wait6", 4'd9);
    check("p15_level6", 32'(water_level), 32'd6);
    check("p15_done_pumping", 32'(pumping), 32'd0);
    check("p15_alarm6", 32'(alarm), 32'd0);

    // Clamp when margin equals remaining distance, then low load goes idle.
    do_load(4'd8);
    check("p8_pumping", 32'(pumping), 32'd1);
    wait_level_change("p8_wait", 4'd8);
    check("p8_clamp", 32'(water_level), 32'd6);
    check("p8_done", 32'(pumping), 32'd0);
    do_load(4'd4);
    check("p4_level", 32'(water_level), 32'd4);
    check("p4_pumping", 32'(pumping), 32'd0);
    repeat (8) step();
    check("p4_held", 32'(water_level), 32'd4);

    // Level 7 paused: rows 0-2 green, no red.
    speed = 2'd0;
    do_load(4'd7);
    step();
    step();
    for (int k = 0; k < 8; k++) begin
      prev = row_data;
      wait_row_change(prev, ok);
      r = row_of(row_data);
      exp_g = (r >= 0 && r < 3) ? 8'hFF : 8'h00;
      check($sformatf("l7_green_row_%0d", r), 32'(green_column_data), 32'(exp_g));
      check($sformatf("l7_red_row_%0d", r), 32'(red_column_data), 32'h00);
    end
    check("l7_level_held", 32'(water_level), 32'd7);

    // Level 15 paused: rows 0-6 red, blinking; never green.
    do_load(4'd15);
    step();
    step();
    on_cnt = 0; off_cnt = 0; bad_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      r = row_of(row_data);
      if (green_column_data !== 8'h00) bad_cnt++;
      if (r >= 0 && r < 7) begin
        if (red_column_data === 8'hFF) on_cnt++;
        else if (red_column_data === 8'h00) off_cnt++;
        else bad_cnt++;
      end else if (red_column_data !== 8'h00) bad_cnt++;
      step();
    end
    check("l15_red_on_seen", 32'(on_cnt > 0), 32'd1);
    check("l15_red_off_seen", 32'(off_cnt > 0), 32'd1);
    check("l15_bad_cols", 32'(bad_cnt), 32'd0);

    // Load landing on a tick wins over the subtraction.
    speed = 2'd3;
    do_load(4'd15);
    wait_level_change("lt_wait12", 4'd15);
    check("lt_level12", 32'(water_level), 32'd12);
    step();
    step();
    step();
    level_in = 4'd10;
    load     = 1'b1;
    step();
    load     = 1'b0;
    check("lt_load_wins", 32'(water_level), 32'd10);
    wait_level_change("lt_wait7", 4'd10);
    check("lt_level7", 32'(water_level), 32'd7);

    // Reset in the middle of pumping.
    do_load(4'd15);
    wait_level_change("mr_wait12", 4'd15);
    check("mr_level12", 32'(water_level), 32'd12);
    rst = 1'b0;
    step();
    check("mr_row_data", 32'(row_data), 32'hFF);
    check("mr_red", 32'(red_column_data), 32'h00);
    check("mr_green", 32'(green_column_data), 32'h00);
    check("mr_level", 32'(water_level), 32'd0);
    check("mr_pumping", 32'(pumping), 32'd0);
    rst = 1'b1;

    // Speed 0 holds the level while still in PUMP.
    speed = 2'd0;
    do_load(4'd13);
    repeat (12) step();
    check("s0_level", 32'(water_level), 32'd13);
    check("s0_pumping", 32'(pumping), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
